// File: rtl/fmul_sched_pkg.sv
// Shared types and constants for the fmul scheduler: FSM states, IEEE flag bit positions,
// datapath widths and the minimum latency the attached fmul needs.
package fmul_sched_pkg;
    localparam int DATA_W       = 32;
    localparam int FLAG_W       = 5;
    localparam int ID_W         = 3;
    localparam int FMUL_MIN_LAT = 5;

    // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
endpackage

// File: rtl/fmul_sched_if.sv
// Request/response/fmul bundle of the fmul scheduler. The acc_clr/acc_flag members exist
// only when FMUL_SCHED_FLAG_ACC_EN is defined.
interface fmul_sched_if
    import fmul_sched_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]        req_valid;
    logic [DATA_W*NREQ-1:0] req_x;
    logic [DATA_W*NREQ-1:0] req_y;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [DATA_W-1:0]      rsp_rslt;
    logic [FLAG_W-1:0]      rsp_flag;
    logic                   fmul_req;
    logic [DATA_W-1:0]      fmul_x;
    logic [DATA_W-1:0]      fmul_y;
    logic [DATA_W-1:0]      fmul_rslt;
    logic [FLAG_W-1:0]      fmul_flag;
`ifdef FMUL_SCHED_FLAG_ACC_EN
    logic [NREQ-1:0]        acc_clr;
    logic [FLAG_W*NREQ-1:0] acc_flag;
`endif

    // Scheduler side
    modport slave (
        input  req_valid, req_x, req_y, rsp_ready, fmul_rslt, fmul_flag,
        output req_ready, rsp_valid, rsp_id, rsp_rslt, rsp_flag, fmul_req, fmul_x, fmul_y
`ifdef FMUL_SCHED_FLAG_ACC_EN
        , input acc_clr, output acc_flag
`endif
    );

    // Requesters, consumer and fmul as seen from outside the scheduler
    modport master (
        output req_valid, req_x, req_y, rsp_ready, fmul_rslt, fmul_flag,
        input  req_ready, rsp_valid, rsp_id, rsp_rslt, rsp_flag, fmul_req, fmul_x, fmul_y
`ifdef FMUL_SCHED_FLAG_ACC_EN
        , output acc_clr, input acc_flag
`endif
    );
endinterface

// File: rtl/fmul_sched_rr_arb.sv
// Combinational round-robin arbiter: picks the first requesting index at or above ptr,
// wrapping to 0, and returns it both one-hot and encoded.
module rr_arb
    import fmul_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx
);
    logic [2*NREQ-1:0] rot;
    logic              found;
    int                pos;

    // Rotating a doubled copy puts the requester at ptr in bit 0
    assign rot = {req, req} >> ptr;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pos   = int'(ptr) + j;
                if (pos >= NREQ) pos = pos - NREQ;
                idx   = ID_W'(pos);
                grant = NREQ'(1) << idx;
            end
        end
    end
endmodule

// File: rtl/fmul_sched.sv
// fmul_sched: shares one multi-cycle fmul among NREQ requesters with round-robin grant.
// Define FMUL_SCHED_FLAG_ACC_EN to add the per-requester sticky flag accumulator.
module fmul_sched
    import fmul_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 5
) (
    input logic         clk,
    input logic         reset,
    fmul_sched_if.slave bus
);
    localparam int CNT_W = $clog2(LAT + 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   op_id_q, op_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fmul_req_q, fmul_req_d;
    logic [DATA_W-1:0] fmul_x_q, fmul_x_d;
    logic [DATA_W-1:0] fmul_y_q, fmul_y_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_rslt_q, rsp_rslt_d;
    logic [FLAG_W-1:0] rsp_flag_q, rsp_flag_d;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_idx;
    logic              rsp_hs;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req  (bus.req_valid),
        .ptr  (rr_ptr_q),
        .grant(grant),
        .idx  (grant_idx)
    );

    assign bus.req_ready = (state_q == IDLE) ? grant : '0;
    assign rsp_hs        = rsp_valid_q & bus.rsp_ready;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_id_d     = op_id_q;
        cnt_d       = cnt_q;
        fmul_req_d  = 1'b0;
        fmul_x_d    = fmul_x_q;
        fmul_y_d    = fmul_y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_rslt_d  = rsp_rslt_q;
        rsp_flag_d  = rsp_flag_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    fmul_x_d   = bus.req_x[DATA_W*grant_idx +: DATA_W];
                    fmul_y_d   = bus.req_y[DATA_W*grant_idx +: DATA_W];
                    op_id_d    = grant_idx;
                    rr_ptr_d   = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    fmul_req_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(LAT - 1);
                state_d = BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                // Last busy cycle: the fmul output is valid now
                if (cnt_q == CNT_W'(1)) begin
                    rsp_rslt_d  = bus.fmul_rslt;
                    rsp_flag_d  = bus.fmul_flag;
                    rsp_id_d    = op_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_id_q     <= '0;
            cnt_q       <= '0;
            fmul_req_q  <= 1'b0;
            fmul_x_q    <= '0;
            fmul_y_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rslt_q  <= '0;
            rsp_flag_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_id_q     <= op_id_d;
            cnt_q       <= cnt_d;
            fmul_req_q  <= fmul_req_d;
            fmul_x_q    <= fmul_x_d;
            fmul_y_q    <= fmul_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rslt_q  <= rsp_rslt_d;
            rsp_flag_q  <= rsp_flag_d;
        end
    end

    assign bus.fmul_req  = fmul_req_q;
    assign bus.fmul_x    = fmul_x_q;
    assign bus.fmul_y    = fmul_y_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rslt  = rsp_rslt_q;
    assign bus.rsp_flag  = rsp_flag_q;

`ifdef FMUL_SCHED_FLAG_ACC_EN
    logic [FLAG_W*NREQ-1:0] acc_q, acc_d;

    // Clear first, then OR in the accepted response, so a same-cycle clear keeps the new flags
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.acc_clr[i]) acc_d[FLAG_W*i +: FLAG_W] = '0;
            if (rsp_hs && (rsp_id_q == ID_W'(i)))
                acc_d[FLAG_W*i +: FLAG_W] = acc_d[FLAG_W*i +: FLAG_W] | rsp_flag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign bus.acc_flag = acc_q;
`endif
endmodule

// File: tb/tb_fmul_sched.sv
// Directed bench for fmul_sched with a table-driven fmul model that only presents a valid
// result on the cycle the scheduler is due to capture it.
module tb_fmul_sched;
    import fmul_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = FMUL_MIN_LAT;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   age      = 0;
    int   req_pulses = 0;
    int   cyc      = 0;
    int   hs_id[$];
    int   hs_cyc[$];
    logic [31:0] rsp_q[$];
    logic [36:0] model;
    int   k;
    logic [31:0] t2_op  [4] = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] t2_exp [4] = '{32'h3f800000, 32'h40800000, 32'h41100000, 32'h41800000};
`ifdef FMUL_SCHED_FLAG_ACC_EN
    logic [NREQ-1:0] clr_at_rsp = '0;
`endif

    fmul_sched_if #(.NREQ(NREQ)) bus ();

    fmul_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] fmul_model(input logic [31:0] x, input logic [31:0] y);
        case ({x, y})
            {32'h40400000, 32'h40000000}: return {5'b00000, 32'h40C00000};
            {32'h3f800000, 32'h3f800000}: return {5'b00000, 32'h3f800000};
            {32'h40000000, 32'h40000000}: return {5'b00000, 32'h40800000};
            {32'h40400000, 32'h40400000}: return {5'b00000, 32'h41100000};
            {32'h40800000, 32'h40800000}: return {5'b00000, 32'h41800000};
            {32'h7f000000, 32'h7f000000}: return {5'b00101, 32'h7f800000};
            {32'h00000000, 32'h7f800000}: return {5'b10000, 32'hffc00000};
            {32'h3eaaaaab, 32'h40400000}: return {5'b00001, 32'h3f800000};
            default:                      return {5'b11111, 32'h7fc00000};
        endcase
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        onehot_idx = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) onehot_idx = i;
    endfunction

    // age counts cycles since the fmul_req cycle; the result is only good at LAT-1
    assign model         = fmul_model(bus.fmul_x, bus.fmul_y);
    assign bus.fmul_rslt = (age == LAT - 1) ? model[31:0]  : 32'hdeadbeef;
    assign bus.fmul_flag = (age == LAT - 1) ? model[36:32] : 5'b11111;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fmul_req) req_pulses <= req_pulses + 1;
        if (bus.fmul_req) age <= 1;
        else if (age != 0 && age < 1000) age <= age + 1;
        if (|(bus.req_valid & bus.req_ready)) begin
            hs_id.push_back(onehot_idx(bus.req_valid & bus.req_ready));
            hs_cyc.push_back(cyc);
        end
        if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(bus.rsp_rslt);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete operation from requester id with rsp_ready held high
    task automatic run_one(input string tag, input int id, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] er, input logic [4:0] ef);
        int n;
        int p0;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = oh;
        bus.req_x[32*id +: 32] = x;
        bus.req_y[32*id +: 32] = y;
        #1;
        n = 0;
        while (bus.req_ready !== oh && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_grant"}, bus.req_ready, oh);
        p0 = req_pulses;
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.req_x = {NREQ{32'hbad0bad0}};
        bus.req_y = {NREQ{32'hbad0bad0}};
        check({tag, "_fmul_req"}, bus.fmul_req, 1'b1);
        check({tag, "_issue_xy"}, {bus.fmul_x, bus.fmul_y}, {x, y});
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_pulses"}, req_pulses - p0, 1);
        check({tag, "_rslt"}, bus.rsp_rslt, er);
        check({tag, "_flag"}, bus.rsp_flag, ef);
        check({tag, "_id"}, bus.rsp_id, id);
        check({tag, "_held_xy"}, {bus.fmul_x, bus.fmul_y}, {x, y});
`ifdef FMUL_SCHED_FLAG_ACC_EN
        bus.acc_clr = clr_at_rsp;
`endif
        @(posedge clk); #1;
`ifdef FMUL_SCHED_FLAG_ACC_EN
        bus.acc_clr = '0;
`endif
        check({tag, "_rsp_drop"}, bus.rsp_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.rsp_ready = 1'b0;
`ifdef FMUL_SCHED_FLAG_ACC_EN
        bus.acc_clr = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_fmul_req", bus.fmul_req, 1'b0);
        check("rst_fmul_xy", {bus.fmul_x, bus.fmul_y}, 64'h0);
        check("rst_rsp_fields", {bus.rsp_id, bus.rsp_flag, bus.rsp_rslt}, 40'h0);
`ifdef FMUL_SCHED_FLAG_ACC_EN
        check("rst_acc", bus.acc_flag, '0);
`endif
        bus.req_valid = 4'b0110;
        #1;
        check("rst_rr_pick", bus.req_ready, 4'b0010);
        bus.req_valid = '0;

        // Basic product, then overflow and invalid cases
        run_one("t1", 0, 32'h40400000, 32'h40000000, 32'h40C00000, 5'b00000);
        run_one("t4_of", 1, 32'h7f000000, 32'h7f000000, 32'h7f800000,
                5'((1 << FLAG_OF) | (1 << FLAG_NX)));
        run_one("t4_nv", 3, 32'h00000000, 32'h7f800000, 32'hffc00000, 5'(1 << FLAG_NV));

        // Response back-pressure: everything frozen while rsp_ready is low
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        bus.req_x[63:32] = 32'h40000000;
        bus.req_y[63:32] = 32'h40000000;
        #1;
        check("t3_grant", bus.req_ready, 4'b0010);
        @(posedge clk); #1;
        bus.req_valid = '0;
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t3_latency", k, LAT);
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("t3_stall%0d", c),
                  {bus.rsp_valid, bus.req_ready, bus.fmul_req, bus.rsp_id, bus.rsp_flag, bus.rsp_rslt},
                  {1'b1, 4'b0000, 1'b0, 3'd1, 5'b00000, 32'h40800000});
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_release_valid", bus.rsp_valid, 1'b0);
        check("t3_release_idle", bus.req_ready, 4'b0100);
        bus.req_valid = '0;

        // Reset while the fmul is busy drops the op and the pointer
        bus.req_valid = 4'b0100;
        bus.req_x[95:64] = 32'h40400000;
        bus.req_y[95:64] = 32'h40400000;
        #1;
        check("t5_grant", bus.req_ready, 4'b0100);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_rsp_valid", bus.rsp_valid, 1'b0);
        check("t5_fmul_xy", {bus.fmul_req, bus.fmul_x, bus.fmul_y}, 65'h0);
        bus.req_valid = 4'b1010;
        #1;
        check("t5_rr_ptr", bus.req_ready, 4'b0010);
        bus.req_valid = '0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) k++;
        end
        check("t5_no_rsp", k, 0);
        run_one("t5_next", 1, 32'h40800000, 32'h40800000, 32'h41800000, 5'b00000);

        // All requesters asserted: strict rotation at minimum spacing
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        hs_id.delete();
        hs_cyc.delete();
        rsp_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x[32*i +: 32] = t2_op[i];
            bus.req_y[32*i +: 32] = t2_op[i];
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        k = 0;
        while (hs_id.size() < 5 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        bus.req_valid = '0;
        check("t2_grants_seen", hs_id.size(), 5);
        for (int i = 0; i < 5 && i < hs_id.size(); i++)
            check($sformatf("t2_order%0d", i), hs_id[i], i % NREQ);
        for (int i = 1; i < 5 && i < hs_id.size(); i++)
            check($sformatf("t2_spacing%0d", i), hs_cyc[i] - hs_cyc[i-1], LAT + 2);
        repeat (12) @(posedge clk);
        #1;
        check("t2_rsp_count", rsp_q.size(), 5);
        for (int i = 0; i < 5 && i < rsp_q.size() && i < hs_id.size(); i++)
            check($sformatf("t2_rslt%0d", i), rsp_q[i], t2_exp[hs_id[i] % NREQ]);

`ifdef FMUL_SCHED_FLAG_ACC_EN
        // Sticky flags for requester 2, then clear on the response handshake
        run_one("t6_of", 2, 32'h7f000000, 32'h7f000000, 32'h7f800000, 5'b00101);
        check("t6_acc_of", bus.acc_flag[10 +: 5], 5'b00101);
        run_one("t6_nx", 2, 32'h3eaaaaab, 32'h40400000, 32'h3f800000, 5'b00001);
        check("t6_acc_sticky", bus.acc_flag[10 +: 5], 5'b00101);
        clr_at_rsp = 4'b0100;
        run_one("t6_clr", 2, 32'h3eaaaaab, 32'h40400000, 32'h3f800000, 5'b00001);
        clr_at_rsp = '0;
        check("t6_acc_clr_set", bus.acc_flag[10 +: 5], 5'b00001);
        check("t6_acc_others", {bus.acc_flag[19:15], bus.acc_flag[9:0]}, 15'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
